// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port data memory.
// Grants are combinational, one transfer per cycle. Read data comes back
// registered one cycle after the grant. A master may hold ownership with its
// lock input for a bounded number of grants while the other master waits.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_a,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_a,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              owner
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    logic              last_q, last_d;
    logic              locked_q, locked_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;

    logic              req_last, req_other;
    logic              gnt_any, gnt_id;
    logic              gnt_we, gnt_lock;
    logic [ADDR_W-1:0] gnt_a;
    logic [DATA_W-1:0] gnt_wd;

    // Grant decision: a bounded lock keeps the last owner, otherwise the
    // master that did not go last wins a tie.
    always_comb begin
        req_last  = last_q ? m1_req : m0_req;
        req_other = last_q ? m0_req : m1_req;
        gnt_any   = 1'b0;
        gnt_id    = 1'b0;
        if (locked_q && req_last && (!req_other || hold_cnt_q < HOLD_MAX)) begin
            gnt_any = 1'b1;
            gnt_id  = last_q;
        end else if (m0_req && m1_req) begin
            gnt_any = 1'b1;
            gnt_id  = ~last_q;
        end else if (m0_req) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
        end else if (m1_req) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    // Memory port mux: the granted master drives the port, idle port is all-zero
    // so no stray peripheral access can occur.
    always_comb begin
        gnt_we   = 1'b0;
        gnt_lock = 1'b0;
        gnt_a    = '0;
        gnt_wd   = '0;
        if (gnt_any) begin
            gnt_we   = gnt_id ? m1_we   : m0_we;
            gnt_lock = gnt_id ? m1_lock : m0_lock;
            gnt_a    = gnt_id ? m1_a    : m0_a;
            gnt_wd   = gnt_id ? m1_wd   : m0_wd;
        end
    end

    assign m0_gnt = gnt_any && !gnt_id;
    assign m1_gnt = gnt_any &&  gnt_id;
    assign mem_we = gnt_we;
    assign mem_a  = gnt_a;
    assign mem_wd = gnt_wd;

    // Next-state: ownership, lock/hold bookkeeping and read-data capture.
    always_comb begin
        last_d      = last_q;
        locked_d    = locked_q;
        hold_cnt_d  = hold_cnt_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        if (gnt_any) begin
            last_d = gnt_id;
            if (gnt_lock) begin
                locked_d = 1'b1;
                if (gnt_id == last_q && locked_q)
                    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + HW'(1);
                else
                    hold_cnt_d = HW'(1);
            end else begin
                locked_d   = 1'b0;
                hold_cnt_d = '0;
            end
            if (!gnt_we) begin
                if (gnt_id) begin
                    m1_rdata_d  = mem_rd;
                    m1_rvalid_d = 1'b1;
                end else begin
                    m0_rdata_d  = mem_rd;
                    m0_rvalid_d = 1'b1;
                end
            end
        end else if (!req_last) begin
            locked_d   = 1'b0;
            hold_cnt_d = '0;
        end
    end

    // State registers; last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b1;
            locked_q    <= 1'b0;
            hold_cnt_q  <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            locked_q    <= locked_d;
            hold_cnt_q  <= hold_cnt_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign owner     = last_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter in front of the single-port data memory and its memory-mapped peripherals (switches at 0xC000_0000, LEDs at 0xC000_0004). Shares the memory port between master 0 (processor data port) and master 1 (a debug loader or DMA).
- Grant decision is combinational; each grant is exactly one memory transfer in that cycle.
- Read data returns registered, one cycle later.
- Fairness is round-robin, with an optional bounded lock for short bursts.

Parameters:
ADDR_W, 32, address width of masters and memory port
DATA_W, 32, data width
MAX_HOLD, 4, max consecutive locked grants to one master while the other is requesting (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 transfer request, valid for the current cycle
m0_we  in  1  master 0 write enable (1=write, 0=read)
m0_lock  in  1  master 0 requests to keep ownership for the next transfer
m0_a  in  ADDR_W  master 0 byte address
m0_wd  in  DATA_W  master 0 write data
m0_gnt  out  1  master 0 transfer accepted this cycle (combinational)
m0_rdata  out  DATA_W  master 0 read data (registered)
m0_rvalid  out  1  master 0 read data valid, one-cycle pulse
m1_req, m1_we, m1_lock, m1_a, m1_wd, m1_gnt, m1_rdata, m1_rvalid: same as master 0, for master 1
mem_we  out  1  to memory: write enable
mem_a  out  ADDR_W  to memory: address
mem_wd  out  DATA_W  to memory: write data
mem_rd  in  DATA_W  from memory: combinational read data for mem_a
owner  out  1  id of the last granted master (registered)

Behaviour:
- State registers:
  - last (1b, id of last granted master)
  - locked (1b, ownership held by last)
  - hold_cnt (width clog2(MAX_HOLD+1))
  - m0/m1 rdata and rvalid
- Reset (async, any time): last=1, so master 0 wins the first tie. locked=0, hold_cnt=0, rdata=0, rvalid=0, owner=1. Combinational outputs keep following inputs during reset.
- Grant selection, same cycle, at most one gnt high:
  - locked=1, req[last]=1 and (other req=0 or hold_cnt<MAX_HOLD) -> grant last.
  - Otherwise, only one req high -> grant it.
  - Otherwise, both high -> grant the master != last.
  - Neither high -> no grant.
- A request without gnt is not consumed. The master holds req/we/a/wd stable until gnt. A req held high after gnt is a new transfer.
- Memory port mux:
  - mem_a, mem_wd and mem_we(=we & gnt) come from the granted master.
  - With no grant: mem_we=0, mem_a=0, mem_wd=0.
  - Addresses pass unmodified, so peripheral decode stays in memory.
- Rising edge with grant to master x:
  - last<=x, owner<=x.
  - If m_x_lock=1: locked<=1 and hold_cnt<=(x==last && locked) ? hold_cnt+1 : 1, saturating at MAX_HOLD.
  - If m_x_lock=0: locked<=0, hold_cnt<=0.
  - If we=0: m_x_rdata<=mem_rd and m_x_rvalid<=1. The other master's rvalid<=0.
  - If we=1: both rvalid<=0; rdata holds.
- Rising edge with no grant: all rvalid<=0. locked/hold_cnt hold only if req[last] is still high, else clear.
- Forced release: when hold_cnt==MAX_HOLD and the other master requests, the other master wins the next tie. That grant clears locked.
- Lock with no competitor: unbounded grants to the owner; hold_cnt saturates.
- Back-to-back transfers: one per cycle. Read latency is gnt cycle + 1.

Test Plan:
1. Reset, then m0 read a=0x10 with RAM[4]=0xDEADBEEF -> m0_gnt=1 same cycle, mem_a=0x10, mem_we=0; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; following cycle m0_rvalid=0.
2. Both req high continuously, no lock, reads -> gnt sequence m0,m1,m0,m1; rvalid pulses alternate one cycle behind.
3. m1 write a=0xC000_0004, wd=0x3FF -> m1_gnt=1, mem_we=1, mem_a=0xC000_0004, mem_wd=0x3FF; m1_rvalid stays 0.
4. MAX_HOLD=4, m0_lock=1, both requesting -> m0 granted 4 cycles, then m1 once, then m0 again with hold_cnt restarted at 1.
5. m0 lock, m1 idle for 10 cycles -> m0 granted 10 consecutive cycles; hold_cnt saturates at 4 without wrap.
6. Reset asserted mid-burst, between clock edges -> rvalid=0, locked=0 immediately; after release, simultaneous requests grant m0 first.
